// File: rtl/hamming_secded_codec.sv
// Bit-serial Hamming SECDED encoder/decoder: scans one codeword position per cycle.
// Optional error counters (corr_cnt/det_cnt) are enabled by defining SECDED_ERR_CNT_EN.
module hamming_secded_codec #(
  parameter int PAR_W = 4
`ifdef SECDED_ERR_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 mode,
  input  logic [2**PAR_W-1:0]  in_word,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2**PAR_W-1:0]  out_word,
  output logic [1:0]           out_err
`ifdef SECDED_ERR_CNT_EN
  , output logic [CNT_W-1:0]   corr_cnt,
  output logic [CNT_W-1:0]     det_cnt
`endif
);

  localparam int CODE_W = 2**PAR_W;
  localparam int DATA_W = CODE_W - PAR_W - 1;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_FIX, S_HOLD} state_t;

  state_t              state_reg, state_next;
  logic                mode_reg;
  logic [CODE_W-1:0]   code_reg;
  logic [PAR_W-1:0]    syn_reg;
  logic                ovr_reg;
  logic [PAR_W-1:0]    idx_reg;
  logic [CODE_W-1:0]   out_word_reg;
  logic [1:0]          out_err_reg;

  logic                accept;
  logic [CODE_W-1:0]   scat_word;
  logic [DATA_W-1:0]   gath_data;
  logic [CODE_W-1:0]   code_fix;
  logic [1:0]          err_fix;

  assign in_ready  = (state_reg == S_IDLE) && !Reset;
  assign out_valid = (state_reg == S_HOLD);
  assign out_word  = out_word_reg;
  assign out_err   = out_err_reg;
  assign accept    = in_valid && in_ready;

  // Data bit at non-power-of-2 position p has index p - (powers of two <= p) - 1.
  genvar gi;
  generate
    for (gi = 0; gi < CODE_W; gi++) begin : g_map
      if (gi >= 3 && (gi & (gi - 1)) != 0) begin : g_data
        localparam int DI = gi - $clog2(gi + 1) - 1;
        assign scat_word[gi] = in_word[DI];
        assign gath_data[DI] = code_fix[gi];
      end else begin : g_par
        assign scat_word[gi] = 1'b0;
      end
    end
  endgenerate

  always_comb begin
    code_fix = code_reg;
    err_fix  = 2'b00;
    if (!mode_reg) begin
      for (int k = 0; k < PAR_W; k++) begin
        code_fix[1 << k] = syn_reg[k];
      end
      code_fix[0] = ovr_reg ^ (^syn_reg);
    end else if (ovr_reg) begin
      // Odd overall parity: single error at position syn (syn==0 means bit 0 itself).
      code_fix[syn_reg] = ~code_reg[syn_reg];
      err_fix = 2'b01;
    end else if (syn_reg != '0) begin
      err_fix = 2'b10;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: if (accept) state_next = S_SCAN;
      S_SCAN: if (idx_reg == PAR_W'(CODE_W - 1)) state_next = S_FIX;
      S_FIX:  state_next = S_HOLD;
      S_HOLD: if (out_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      mode_reg     <= 1'b0;
      code_reg     <= '0;
      syn_reg      <= '0;
      ovr_reg      <= 1'b0;
      idx_reg      <= '0;
      out_word_reg <= '0;
      out_err_reg  <= 2'b00;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (accept) begin
            mode_reg <= mode;
            code_reg <= mode ? in_word : scat_word;
            syn_reg  <= '0;
            ovr_reg  <= mode ? in_word[0] : 1'b0;
            idx_reg  <= PAR_W'(1);
          end
        end
        S_SCAN: begin
          if (code_reg[idx_reg]) begin
            syn_reg <= syn_reg ^ idx_reg;
            ovr_reg <= ~ovr_reg;
          end
          idx_reg <= idx_reg + PAR_W'(1);
        end
        S_FIX: begin
          out_word_reg <= mode_reg ? CODE_W'(gath_data) : code_fix;
          out_err_reg  <= err_fix;
        end
        default: ;
      endcase
    end
  end

`ifdef SECDED_ERR_CNT_EN
  logic [CNT_W-1:0] corr_cnt_reg;
  logic [CNT_W-1:0] det_cnt_reg;

  assign corr_cnt = corr_cnt_reg;
  assign det_cnt  = det_cnt_reg;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      corr_cnt_reg <= '0;
      det_cnt_reg  <= '0;
    end else if (state_reg == S_FIX && mode_reg) begin
      if (err_fix == 2'b01 && corr_cnt_reg != '1) corr_cnt_reg <= corr_cnt_reg + 1'b1;
      if (err_fix == 2'b10 && det_cnt_reg != '1)  det_cnt_reg  <= det_cnt_reg + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hamming_secded_codec.sv
// Randomised self-checking bench for hamming_secded_codec against a parity-group reference model.
module tb_hamming_secded_codec;

  localparam int PAR_W  = 4;
  localparam int CODE_W = 16;
  localparam int DATA_W = 11;
  localparam int CNT_W  = 16;

  logic              Clk = 1'b0;
  logic              Reset = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              mode = 1'b0;
  logic [CODE_W-1:0] in_word = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [CODE_W-1:0] out_word;
  logic [1:0]        out_err;
`ifdef SECDED_ERR_CNT_EN
  logic [CNT_W-1:0]  corr_cnt;
  logic [CNT_W-1:0]  det_cnt;
`endif

  int n_pass = 0;
  int n_total = 0;

  always #5 Clk = ~Clk;

  hamming_secded_codec #(
    .PAR_W(PAR_W)
`ifdef SECDED_ERR_CNT_EN
    , .CNT_W(CNT_W)
`endif
  ) dut (
    .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
    .in_word(in_word), .out_valid(out_valid), .out_ready(out_ready),
    .out_word(out_word), .out_err(out_err)
`ifdef SECDED_ERR_CNT_EN
    , .corr_cnt(corr_cnt), .det_cnt(det_cnt)
`endif
  );

  // Reference: each parity bit 2**k is the even parity of every position with bit k set.
  function automatic logic [CODE_W-1:0] ref_encode(input logic [DATA_W-1:0] d);
    logic [CODE_W-1:0] c;
    int j;
    logic par;
    c = '0;
    j = 0;
    for (int p = 1; p < CODE_W; p++) begin
      if ((p & (p - 1)) != 0) begin
        c[p] = d[j];
        j++;
      end
    end
    for (int k = 0; k < PAR_W; k++) begin
      par = 1'b0;
      for (int p = 1; p < CODE_W; p++) if (((p >> k) & 1) == 1) par ^= c[p];
      c[1 << k] = par;
    end
    c[0] = ^c[CODE_W-1:1];
    return c;
  endfunction

  function automatic logic [DATA_W-1:0] ref_extract(input logic [CODE_W-1:0] c);
    logic [DATA_W-1:0] d;
    int j;
    d = '0;
    j = 0;
    for (int p = 1; p < CODE_W; p++) begin
      if ((p & (p - 1)) != 0) begin
        d[j] = c[p];
        j++;
      end
    end
    return d;
  endfunction

  task automatic cycle();
    @(posedge Clk);
    #1;
  endtask

  // One request/response; lat counts clock edges after the accept edge until out_valid.
  task automatic run(input logic m, input logic [CODE_W-1:0] w,
                     output logic [CODE_W-1:0] ow, output logic [1:0] oe, output int lat);
    int wt;
    wt = 0;
    while (!in_ready && wt < 50) begin
      cycle();
      wt++;
    end
    in_valid = 1'b1;
    mode     = m;
    in_word  = w;
    cycle();
    in_valid = 1'b0;
    mode     = 1'($urandom);
    in_word  = CODE_W'($urandom);
    lat = 0;
    while (!out_valid && lat < 100) begin
      cycle();
      lat++;
    end
    ow = out_word;
    oe = out_err;
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    $display("txn mode=%0d in=%04h -> out=%04h err=%0d lat=%0d", m, w, ow, oe, lat);
  endtask

  task automatic check_txn(input string name, input logic m, input logic [CODE_W-1:0] w,
                           input logic [CODE_W-1:0] exp_w, input logic [1:0] exp_e);
    logic [CODE_W-1:0] ow;
    logic [1:0] oe;
    int lat;
    run(m, w, ow, oe, lat);
    n_total++;
    if (lat !== CODE_W) $display("FAIL %s latency: got %0d edges, expected %0d", name, lat, CODE_W);
    else n_pass++;
    n_total++;
    if (ow !== exp_w) $display("FAIL %s word: got %04h, expected %04h", name, ow, exp_w);
    else n_pass++;
    n_total++;
    if (oe !== exp_e) $display("FAIL %s err: got %0d, expected %0d", name, oe, exp_e);
    else n_pass++;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (3) cycle();
    n_total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_word !== '0 || out_err !== 2'b00)
      $display("FAIL reset_state: rdy=%b vld=%b word=%04h err=%0d, expected 0 0 0000 0",
               in_ready, out_valid, out_word, out_err);
    else n_pass++;
    Reset = 1'b0;
    #1;
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL reset_release: in_ready=%b, expected 1", in_ready);
    else n_pass++;
  endtask

  task automatic test_encode_vectors();
    check_txn("enc_000", 1'b0, 16'h0000, 16'h0000, 2'b00);
    check_txn("enc_7ff", 1'b0, 16'h07FF, 16'hFFFF, 2'b00);
    check_txn("enc_001", 1'b0, 16'h0001, 16'h000F, 2'b00);
    check_txn("enc_upper_ignored", 1'b0, 16'hF801, 16'h000F, 2'b00);
  endtask

  task automatic test_decode_vectors();
    check_txn("dec_clean", 1'b1, 16'h000F, 16'h0001, 2'b00);
    check_txn("dec_pos9",  1'b1, 16'h020F, 16'h0001, 2'b01);
    check_txn("dec_pos2",  1'b1, 16'h000B, 16'h0001, 2'b01);
    check_txn("dec_bit0",  1'b1, 16'h000E, 16'h0001, 2'b01);
    check_txn("dec_double", 1'b1, 16'h003F, 16'h0003, 2'b10);
  endtask

  task automatic test_random();
    logic [DATA_W-1:0] d;
    logic [CODE_W-1:0] c;
    int nflip, p1, p2;
    for (int t = 0; t < 40; t++) begin
      d = DATA_W'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        check_txn("rnd_enc", 1'b0, {5'($urandom), d}, ref_encode(d), 2'b00);
      end else begin
        c = ref_encode(d);
        nflip = $urandom_range(0, 2);
        p1 = $urandom_range(0, CODE_W - 1);
        p2 = (p1 + $urandom_range(1, CODE_W - 1)) % CODE_W;
        if (nflip >= 1) c[p1] = ~c[p1];
        if (nflip == 2) c[p2] = ~c[p2];
        if (nflip == 2) check_txn("rnd_dec2", 1'b1, c, CODE_W'(ref_extract(c)), 2'b10);
        else check_txn(nflip == 1 ? "rnd_dec1" : "rnd_dec0", 1'b1, c, CODE_W'(d), 2'(nflip));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [CODE_W-1:0] exp_w;
    int lat;
    exp_w = ref_encode(11'h5A5);
    in_valid = 1'b1;
    mode = 1'b0;
    in_word = 16'h05A5;
    cycle();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      cycle();
      lat++;
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      mode = 1'($urandom);
      in_word = CODE_W'($urandom);
      cycle();
      n_total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_word !== exp_w || out_err !== 2'b00)
        $display("FAIL hold_%0d: vld=%b rdy=%b word=%04h err=%0d, expected 1 0 %04h 0",
                 i, out_valid, in_ready, out_word, out_err, exp_w);
      else n_pass++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    $display("txn mode=0 in=05a5 -> out=%04h held under backpressure", exp_w);
    n_total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL hold_release: rdy=%b vld=%b, expected 1 0", in_ready, out_valid);
    else n_pass++;
  endtask

  task automatic test_reset_mid_scan();
    int seen;
    in_valid = 1'b1;
    mode = 1'b1;
    in_word = 16'h020F;
    cycle();
    in_valid = 1'b0;
    repeat (5) cycle();
    Reset = 1'b1;
    cycle();
    n_total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0)
      $display("FAIL reset_mid_scan: vld=%b rdy=%b, expected 0 0", out_valid, in_ready);
    else n_pass++;
    Reset = 1'b0;
    cycle();
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      if (out_valid) seen++;
      cycle();
    end
    $display("txn mode=1 in=020f aborted by reset");
    n_total++;
    if (seen != 0 || in_ready !== 1'b1)
      $display("FAIL reset_no_stale: valid cycles=%0d rdy=%b, expected 0 1", seen, in_ready);
    else n_pass++;
  endtask

`ifdef SECDED_ERR_CNT_EN
  task automatic test_counters();
    Reset = 1'b1;
    cycle();
    Reset = 1'b0;
    check_txn("cnt_c1", 1'b1, 16'h020F, 16'h0001, 2'b01);
    check_txn("cnt_enc", 1'b0, 16'h0001, 16'h000F, 2'b00);
    check_txn("cnt_c2", 1'b1, 16'h000B, 16'h0001, 2'b01);
    check_txn("cnt_d1", 1'b1, 16'h003F, 16'h0003, 2'b10);
    n_total++;
    if (corr_cnt !== 16'd2 || det_cnt !== 16'd1)
      $display("FAIL counters: corr=%0d det=%0d, expected 2 1", corr_cnt, det_cnt);
    else n_pass++;
    Reset = 1'b1;
    cycle();
    Reset = 1'b0;
    n_total++;
    if (corr_cnt !== '0 || det_cnt !== '0)
      $display("FAIL counters_reset: corr=%0d det=%0d, expected 0 0", corr_cnt, det_cnt);
    else n_pass++;
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    test_reset();
    test_encode_vectors();
    test_decode_vectors();
    test_random();
    test_backpressure();
    test_reset_mid_scan();
`ifdef SECDED_ERR_CNT_EN
    test_counters();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
